k12a_mem_arbiter: RTL and testbench
===================================

# k12a_mem_arbiter

Shares the single k12a data-memory port between the CPU datapath and an external DMA/debug requester. Each cycle exactly one master owns the port. The owner is held in a register and decided at each clock edge, using CPU idle cycles, a starvation limit and a burst limit. When the DMA side owns the port and the CPU wants memory, the arbiter stalls the CPU. The block sits between the k12a core's memory-control outputs (mem_enable/mem_mode, address bus, data bus) and the memory array, which has combinational read and write-on-clock.

## Interface
- STARVE_LIMIT, default 8: maximum number of consecutive cycles a DMA request waits while the CPU keeps using memory (range 1-255).
- MAX_DMA_BURST, default 4: maximum consecutive DMA-owned cycles while the CPU is waiting (range 1-255).
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_mem_enable  in  1  CPU requests the memory this cycle.
- cpu_mem_mode  in  mem_mode_t  MEM_MODE_READ / MEM_MODE_WRITE.
- cpu_addr  in  16  CPU address bus.
- cpu_wdata  in  8  CPU data bus (write data).
- cpu_rdata  out  8  read data to CPU; equals mem_rdata.
- cpu_stall  out  1  CPU must hold all state this cycle.
- dma_req  in  1  DMA access requested; held until dma_gnt is seen.
- dma_we  in  1  1 = write, 0 = read.
- dma_addr  in  16  DMA address.
- dma_wdata  in  8  DMA write data.
- dma_gnt  out  1  DMA access performed this cycle.
- dma_rdata  out  8  read data to DMA; equals mem_rdata.
- mem_enable  out  1  memory select.
- mem_mode  out  mem_mode_t  memory direction.
- mem_addr  out  16  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data (combinational).

## Operation
- Owner register: OWNER_CPU or OWNER_DMA. Reset value is OWNER_CPU.
- Other state:
  - wait_cnt (8 bit): cycles dma_req has been pending under OWNER_CPU.
  - burst_cnt (8 bit): DMA cycles granted since the last CPU-owned cycle.
  - Both reset to 0.
- OWNER_CPU:
  - mem_* follow the cpu_* inputs.
  - dma_gnt = 0 and cpu_stall = 0.
- OWNER_DMA:
  - mem_enable = 1, mem_mode = dma_we ? WRITE : READ, mem_addr = dma_addr, mem_wdata = dma_wdata.
  - dma_gnt = 1.
  - cpu_stall = cpu_mem_enable.
- Transitions out of OWNER_CPU:
  - Go to OWNER_DMA if dma_req && (!cpu_mem_enable || wait_cnt == STARVE_LIMIT-1); clear wait_cnt and burst_cnt.
  - Otherwise, if dma_req, wait_cnt increments, saturating at STARVE_LIMIT-1.
  - Otherwise, wait_cnt is cleared.
- Transitions out of OWNER_DMA:
  - Go to OWNER_CPU if !dma_req (registered at the edge).
  - Go to OWNER_CPU if cpu_mem_enable && burst_cnt == MAX_DMA_BURST-1.
  - Otherwise stay in OWNER_DMA; burst_cnt increments while cpu_mem_enable and is cleared while !cpu_mem_enable.
- Requester protocol: dma_req and the DMA inputs are held stable until the requester samples dma_gnt = 1. One grant cycle equals one byte transferred.
- If dma_req drops while in OWNER_DMA and no grant has been taken, the owner returns to OWNER_CPU at the next edge.
- A halted CPU (cpu_mem_enable permanently 0) gives the DMA side unlimited back-to-back grants.
- Simultaneous events:
  - The burst limit and a dma_req drop in the same cycle both yield OWNER_CPU.
  - A starvation hit and an idle CPU in the same cycle both yield OWNER_DMA.
- Reset mid-operation: owner returns to OWNER_CPU immediately (asynchronously) and the counters clear. An in-flight DMA write on that cycle is not guaranteed.

## Timing
- Ownership changes only on the clock edge. All outputs are combinational from the owner register and the current inputs; no output register stage.
- Latencies:
  - dma_req rising to first dma_gnt: 1 cycle if the CPU is idle, at most STARVE_LIMIT cycles otherwise.
  - Read data is valid in the grant cycle itself (combinational memory).
- A stalled CPU resumes at most MAX_DMA_BURST cycles after the stall began.
- Outputs during and after reset: dma_gnt = 0, cpu_stall = 0, mem_* follow the cpu_* inputs.

## Structure
- Add to k12a.inc.sv: mem_owner_t enum (OWNER_CPU, OWNER_DMA). mem_mode_t is reused from there.
- One sub-module fits naturally: k12a_sat_counter (8-bit, inputs inc/clear, saturating at a limit input), instanced for wait_cnt and burst_cnt.
- The CPU-side integration gates the state register and all register store strobes with !cpu_stall. That change lives in the core top level, not in this block.

## Test plan
- Reset, then CPU reads 0x1234: mem_addr = 0x1234, cpu_stall = 0, dma_gnt = 0. Asserting reset mid-DMA returns owner to CPU in the same cycle.
- CPU idle (cpu_mem_enable = 0), dma_req with write 0xAB to 0x8010: dma_gnt the next cycle, mem_mode = WRITE, and a later CPU read of 0x8010 returns 0xAB.
- CPU requests every cycle, dma_req held: first dma_gnt occurs exactly 8 cycles after dma_req rises (STARVE_LIMIT = 8), with cpu_stall = 1 during grants.
- Continuing the previous case with dma_req held: exactly 4 consecutive grants, then one CPU-owned cycle with cpu_stall = 0, then the pattern repeats.
- CPU halted (cpu_mem_enable = 0 forever), 16-byte DMA read burst: 16 consecutive grants, dma_rdata matches memory contents, no CPU-owned gaps.
- dma_req drops in the same cycle the burst limit hits: owner is CPU next cycle, wait_cnt = 0, and no spurious dma_gnt.

Source files
------------

// File: rtl/k12a_mem_arbiter_pkg.sv
// Shared types and widths for the k12a data-memory arbiter.
package k12a_mem_arbiter_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 8;

  // Direction of a memory access, shared with the k12a core.
  typedef enum logic {
    MEM_MODE_READ  = 1'b0,
    MEM_MODE_WRITE = 1'b1
  } mem_mode_t;

  // Which master drives the memory port in the current cycle.
  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } mem_owner_t;

  // Terminal count for a limit given as a cycle count (limit 1 -> terminal 0).
  function automatic logic [CNT_W-1:0] last_count(input int unsigned limit);
    return CNT_W'(limit - 1);
  endfunction

endpackage

// File: rtl/k12a_mem_arbiter_if.sv
// Bundle of the CPU, DMA and memory-array buses around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface k12a_mem_arbiter_if;
  import k12a_mem_arbiter_pkg::*;

  // CPU datapath side
  logic              cpu_mem_enable;
  mem_mode_t         cpu_mem_mode;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  // DMA / debug requester side
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;

  // Memory array side
  logic              mem_enable;
  mem_mode_t         mem_mode;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_mem_enable, cpu_mem_mode, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata,
    output mem_enable, mem_mode, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_mem_enable, cpu_mem_mode, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata,
    input  mem_enable, mem_mode, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/k12a_sat_counter.sv
// 8-bit up-counter with synchronous clear that stops at a programmable limit.
module k12a_sat_counter
  import k12a_mem_arbiter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Next count: clear wins over increment; increment holds once the limit is reached.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q < limit)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/k12a_mem_arbiter.sv
// Arbitrates the single k12a data-memory port between the CPU datapath and a
// DMA/debug requester. Ownership is registered and changes only on the clock
// edge; every output is combinational from the owner and the current inputs.
module k12a_mem_arbiter
  import k12a_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT  = 8,
  parameter int unsigned MAX_DMA_BURST = 4
) (
  input logic                  clock,
  input logic                  reset,
  k12a_mem_arbiter_if.slave    bus
);

  localparam logic [CNT_W-1:0] WAIT_LAST  = last_count(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] BURST_LAST = last_count(MAX_DMA_BURST);

  mem_owner_t       owner_d;
  mem_owner_t       owner_q;

  logic             wait_inc;
  logic             wait_clr;
  logic             burst_inc;
  logic             burst_clr;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] burst_cnt;

  // Cycles a DMA request has been held off while the CPU keeps the port busy.
  k12a_sat_counter u_wait_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (wait_inc),
    .clear (wait_clr),
    .limit (WAIT_LAST),
    .count (wait_cnt)
  );

  // DMA-owned cycles taken back-to-back while the CPU is waiting for memory.
  k12a_sat_counter u_burst_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (burst_inc),
    .clear (burst_clr),
    .limit (BURST_LAST),
    .count (burst_cnt)
  );

  // Owner register; reset hands the port back to the CPU immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q <= OWNER_CPU;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Next owner and counter strobes.
  always_comb begin
    owner_d   = owner_q;
    wait_inc  = 1'b0;
    wait_clr  = 1'b0;
    burst_inc = 1'b0;
    burst_clr = 1'b0;
    case (owner_q)
      OWNER_CPU: begin
        // A burst only spans DMA cycles since the last CPU-owned cycle.
        burst_clr = 1'b1;
        if (bus.dma_req && (!bus.cpu_mem_enable || (wait_cnt == WAIT_LAST))) begin
          // Idle CPU slot or starvation limit reached: hand over the port.
          owner_d  = OWNER_DMA;
          wait_clr = 1'b1;
        end else if (bus.dma_req) begin
          wait_inc = 1'b1;
        end else begin
          wait_clr = 1'b1;
        end
      end
      OWNER_DMA: begin
        wait_clr = 1'b1;
        if (!bus.dma_req || (bus.cpu_mem_enable && (burst_cnt == BURST_LAST))) begin
          // Request withdrawn, or the waiting CPU has had to wait long enough.
          owner_d = OWNER_CPU;
        end else if (bus.cpu_mem_enable) begin
          burst_inc = 1'b1;
        end else begin
          // A halted/idle CPU does not consume burst budget.
          burst_clr = 1'b1;
        end
      end
      default: begin
        owner_d = OWNER_CPU;
      end
    endcase
  end

  // Memory port steering, grant and stall.
  always_comb begin
    bus.cpu_rdata  = bus.mem_rdata;
    bus.dma_rdata  = bus.mem_rdata;
    bus.mem_enable = bus.cpu_mem_enable;
    bus.mem_mode   = bus.cpu_mem_mode;
    bus.mem_addr   = bus.cpu_addr;
    bus.mem_wdata  = bus.cpu_wdata;
    bus.dma_gnt    = 1'b0;
    bus.cpu_stall  = 1'b0;
    if (owner_q == OWNER_DMA) begin
      // A grant (and the memory access behind it) needs a live request; a
      // request dropped before its grant must not write stale DMA data.
      bus.mem_enable = bus.dma_req;
      bus.mem_mode   = bus.dma_we ? MEM_MODE_WRITE : MEM_MODE_READ;
      bus.mem_addr   = bus.dma_addr;
      bus.mem_wdata  = bus.dma_wdata;
      bus.dma_gnt    = bus.dma_req;
      bus.cpu_stall  = bus.cpu_mem_enable;
    end
  end

endmodule

// File: tb/tb_k12a_mem_arbiter.sv
module tb_k12a_mem_arbiter;
  import k12a_mem_arbiter_pkg::*;

  localparam int SL = 8;
  localparam int MB = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  k12a_mem_arbiter_if bus ();

  k12a_mem_arbiter #(
    .STARVE_LIMIT  (SL),
    .MAX_DMA_BURST (MB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Memory array: combinational read, write on clock.
  logic [7:0] mem_arr [0:65535];
  assign bus.mem_rdata = mem_arr[bus.mem_addr];
  always @(posedge clock) begin
    if (bus.mem_enable && (bus.mem_mode == MEM_MODE_WRITE)) mem_arr[bus.mem_addr] <= bus.mem_wdata;
  end

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 37) ^ (a >> 8) ^ 8'h5A);
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) mem_arr[i] <= pat(i);
  end

  // Reference: expected memory contents and arbitration state.
  logic [7:0] shadow [0:65535];
  bit         m_dma_owns;
  int         m_waited;
  int         m_burst;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } dma_xfer_t;
  dma_xfer_t dma_q [$];

  int checks   = 0;
  int failures = 0;

  logic        saw_gnt;
  logic        saw_stall;
  logic        saw_mode_wr;
  logic [15:0] saw_mem_addr;
  logic [7:0]  saw_cpu_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dma_owns = 1'b0;
    m_waited   = 0;
    m_burst    = 0;
  endtask

  // Present the head of the requester queue; dma_req stays up until granted.
  task automatic drive_dma();
    if (dma_q.size() > 0) begin
      bus.dma_req   = 1'b1;
      bus.dma_we    = dma_q[0].we;
      bus.dma_addr  = dma_q[0].addr;
      bus.dma_wdata = dma_q[0].wdata;
    end else begin
      bus.dma_req = 1'b0;
    end
  endtask

  task automatic cpu_set(input logic en, input logic wr, input logic [15:0] a, input logic [7:0] d);
    bus.cpu_mem_enable = en;
    bus.cpu_mem_mode   = wr ? MEM_MODE_WRITE : MEM_MODE_READ;
    bus.cpu_addr       = a;
    bus.cpu_wdata      = d;
  endtask

  // One clock cycle: check outputs against the reference mid-cycle, advance
  // the reference at the edge, then let the requester react to its grant.
  task automatic tick();
    logic        cen, cwr, req, e_en, e_wr, e_gnt, e_stall;
    logic [15:0] e_addr;
    logic [7:0]  e_wd;
    @(negedge clock);
    cen = bus.cpu_mem_enable;
    cwr = (bus.cpu_mem_mode == MEM_MODE_WRITE);
    req = bus.dma_req;
    if (m_dma_owns) begin
      e_en = req; e_wr = bus.dma_we; e_addr = bus.dma_addr; e_wd = bus.dma_wdata;
      e_gnt = req; e_stall = cen;
    end else begin
      e_en = cen; e_wr = cwr; e_addr = bus.cpu_addr; e_wd = bus.cpu_wdata;
      e_gnt = 1'b0; e_stall = 1'b0;
    end
    chk("mem_enable", 32'(bus.mem_enable), 32'(e_en));
    chk("mem_mode",   32'(bus.mem_mode == MEM_MODE_WRITE), 32'(e_wr));
    chk("mem_addr",   32'(bus.mem_addr), 32'(e_addr));
    if (e_en && e_wr) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
    chk("dma_gnt",    32'(bus.dma_gnt), 32'(e_gnt));
    chk("cpu_stall",  32'(bus.cpu_stall), 32'(e_stall));
    if (e_en && !e_wr && !e_gnt) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(shadow[e_addr]));
    if (e_gnt && !e_wr) chk("dma_rdata", 32'(bus.dma_rdata), 32'(shadow[e_addr]));
    saw_gnt       = bus.dma_gnt;
    saw_stall     = bus.cpu_stall;
    saw_mode_wr   = (bus.mem_mode == MEM_MODE_WRITE);
    saw_mem_addr  = bus.mem_addr;
    saw_cpu_rdata = bus.cpu_rdata;
    @(posedge clock);
    if (e_en && e_wr) shadow[e_addr] = e_wd;
    if (reset) begin
      model_reset();
    end else if (!m_dma_owns) begin
      if (req && (!cen || m_waited == SL - 1)) begin
        m_dma_owns = 1'b1;
        m_waited   = 0;
        m_burst    = 0;
      end else if (req) begin
        m_waited = (m_waited + 1 > SL - 1) ? SL - 1 : m_waited + 1;
      end else begin
        m_waited = 0;
      end
    end else begin
      if (!req || (cen && m_burst == MB - 1)) m_dma_owns = 1'b0;
      else if (cen) m_burst = m_burst + 1;
      else m_burst = 0;
    end
    #1;
    if (saw_gnt && dma_q.size() > 0) dma_q.delete(0);
    drive_dma();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int grants;
    dma_xfer_t x;

    for (int i = 0; i < 65536; i++) shadow[i] = pat(i);
    model_reset();
    reset = 1'b1;
    cpu_set(1'b1, 1'b0, 16'h4321, 8'h00);
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h7777; bus.dma_wdata = 8'hEE;
    #1;
    chk("rst_gnt",   32'(bus.dma_gnt), 32'd0);
    chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rst_addr",  32'(bus.mem_addr), 32'h4321);
    tick();
    tick();
    reset = 1'b0;
    bus.dma_req = 1'b0;

    // CPU read of 0x1234
    cpu_set(1'b1, 1'b0, 16'h1234, 8'h00);
    tick();
    chk("cpu_read_addr",  32'(saw_mem_addr), 32'h1234);
    chk("cpu_read_stall", 32'(saw_stall), 32'd0);
    chk("cpu_read_gnt",   32'(saw_gnt), 32'd0);

    // Idle CPU, DMA write 0xAB to 0x8010
    cpu_set(1'b0, 1'b0, 16'h0000, 8'h00);
    x.we = 1'b1; x.addr = 16'h8010; x.wdata = 8'hAB;
    dma_q.push_back(x);
    drive_dma();
    tick();
    chk("idle_first_gnt", 32'(saw_gnt), 32'd0);
    tick();
    chk("idle_gnt",      32'(saw_gnt), 32'd1);
    chk("idle_gnt_mode", 32'(saw_mode_wr), 32'd1);
    cpu_set(1'b1, 1'b0, 16'h8010, 8'h00);
    tick();
    tick();
    chk("readback_stall", 32'(saw_stall), 32'd0);
    chk("readback_data",  32'(saw_cpu_rdata), 32'hAB);

    // Busy CPU: starvation limit, then burst limit
    cpu_set(1'b1, 1'b0, 16'h2000, 8'h00);
    tick();
    for (int i = 0; i < 20; i++) begin
      x.we = 1'b0; x.addr = 16'h9000 + 16'(i); x.wdata = 8'h00;
      dma_q.push_back(x);
    end
    drive_dma();
    n = 0;
    do begin tick(); n++; end while (!saw_gnt && n < 40);
    chk("starve_latency", 32'(n - 1), 32'(SL));
    chk("starve_stall",   32'(saw_stall), 32'd1);
    for (int rep = 0; rep < 2; rep++) begin
      if (rep == 1) begin
        n = 0;
        do begin tick(); n++; end while (!saw_gnt && n < 40);
        chk("repeat_gnt_seen", 32'(saw_gnt), 32'd1);
      end
      grants = 1;
      n = 0;
      do begin
        tick(); n++;
        if (saw_gnt) grants++;
      end while (saw_gnt && n < 40);
      chk("burst_len",       32'(grants), 32'(MB));
      chk("burst_cpu_stall", 32'(saw_stall), 32'd0);
    end
    dma_q.delete();
    drive_dma();
    tick();
    tick();

    // Halted CPU: 16-byte DMA read burst
    cpu_set(1'b0, 1'b0, 16'h0000, 8'h00);
    for (int i = 0; i < 16; i++) begin
      x.we = 1'b0; x.addr = 16'hA000 + 16'(i * 3); x.wdata = 8'h00;
      dma_q.push_back(x);
    end
    drive_dma();
    n = 0;
    do begin tick(); n++; end while (!saw_gnt && n < 10);
    chk("halted_latency", 32'(n - 1), 32'd1);
    grants = 1;
    n = 0;
    do begin
      tick(); n++;
      if (saw_gnt) grants++;
    end while (saw_gnt && n < 40);
    chk("halted_burst", 32'(grants), 32'd16);
    tick();

    // Request drops in the same cycle the burst limit is reached
    cpu_set(1'b1, 1'b0, 16'h3000, 8'h00);
    for (int i = 0; i < MB - 1; i++) begin
      x.we = 1'b0; x.addr = 16'hB000 + 16'(i); x.wdata = 8'h00;
      dma_q.push_back(x);
    end
    drive_dma();
    grants = 0;
    n = 0;
    do begin
      tick(); n++;
      if (saw_gnt) grants++;
    end while (grants < MB - 1 && n < 40);
    chk("drop_grants", 32'(grants), 32'(MB - 1));
    tick();
    chk("drop_no_gnt",   32'(saw_gnt), 32'd0);
    chk("drop_stall",    32'(saw_stall), 32'd1);
    chk("drop_owner_gnt",   32'(bus.dma_gnt), 32'd0);
    chk("drop_owner_stall", 32'(bus.cpu_stall), 32'd0);
    chk("drop_wait_cnt",    32'(dut.wait_cnt), 32'd0);
    tick();

    // Randomized traffic on a small shared address window
    for (int cyc = 0; cyc < 400; cyc++) begin
      cpu_set(($urandom_range(0, 3) != 0) && (cyc % 100 < 70), 1'($urandom_range(0, 1)),
              16'h8000 | 16'($urandom_range(0, 15)), 8'($urandom));
      if (dma_q.size() == 0 && $urandom_range(0, 3) == 0) begin
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) begin
          x.we = 1'($urandom_range(0, 1));
          x.addr = 16'h8000 | 16'($urandom_range(0, 15));
          x.wdata = 8'($urandom);
          dma_q.push_back(x);
        end
        drive_dma();
      end
      tick();
    end

    // Reset asserted while the DMA side owns the port
    cpu_set(1'b0, 1'b0, 16'h5555, 8'h00);
    for (int i = 0; i < 6; i++) begin
      x.we = 1'b0; x.addr = 16'hC000 + 16'(i); x.wdata = 8'h00;
      dma_q.push_back(x);
    end
    drive_dma();
    n = 0;
    do begin tick(); n++; end while (!saw_gnt && n < 10);
    chk("pre_reset_gnt", 32'(saw_gnt), 32'd1);
    cpu_set(1'b1, 1'b0, 16'h5555, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_reset_gnt",   32'(bus.dma_gnt), 32'd0);
    chk("mid_reset_stall", 32'(bus.cpu_stall), 32'd0);
    chk("mid_reset_addr",  32'(bus.mem_addr), 32'h5555);
    chk("mid_reset_burst", 32'(dut.burst_cnt), 32'd0);
    model_reset();
    dma_q.delete();
    drive_dma();
    tick();
    reset = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
